trace_logger_ring: RTL
======================

Name: trace_logger_ring

Overview:
Parametrised next-generation trace logger between the Tracer and a single-port trace RAM.
- Accepts trace words from the Tracer and stores them in a ring buffer.
- Handles trigger delay for pre/post-trigger ratio and serves memory reads back to the Tracer.
- Arbitrates the shared RAM port internally, replacing the external RW turn strobe.
- Adds a stream mode (lossless FIFO) alongside trace mode (overwrite-oldest ring), an occupancy count and drop reporting.

Parameters:
WIDTH, 32, trace word width in bits
DEPTH, 64, ring entries; power of two, >=4
DELAY_BITS, 3, width of trigger-delay fraction
AW, $clog2(DEPTH), address width (derived, not overridden)

Ports:
CLK_I  in  1  clock
RST_NI  in  1  reset, asynchronous, active-low
CLEAR_I  in  1  sync clear of pointers/count/trigger/flags; latches MODE_I
MODE_I  in  1  0 = trace (overwrite), 1 = stream (lossless)
TRG_DELAY_I  in  DELAY_BITS  post-trigger fraction of DEPTH
TRG_EVENT_I  in  1  trigger event from Tracer
TRG_DELAYED_O  out  1  trigger seen and post-trigger writes done
EVENT_ADDR_O  out  AW  write pointer when trigger first seen
STORE_I  in  1  Tracer store strobe
DATA_I  in  WIDTH  trace word
STORE_PERM_O  out  1  store will be accepted this cycle
LOAD_REQUEST_I  in  1  Tracer read request
LOAD_GRANT_O  out  1  one-cycle pulse; DATA_O valid
DATA_O  out  WIDTH  read word
FILL_O  out  AW+1  committed entries, 0..DEPTH
OVERFLOW_O  out  1  sticky: a store was dropped
MEM_WE_O  out  1  RAM write enable
MEM_ADDR_O  out  AW  RAM address
MEM_WDATA_O  out  WIDTH  RAM write data
MEM_RDATA_I  in  WIDTH  RAM read data, 1-cycle latency after address

Behaviour:
- Reset values: all outputs 0; wr_ptr = rd_ptr = 0; mode = trace.
- Async reset mid-read discards the read; no grant is issued.
- CLEAR_I (sync, highest priority): same state as reset except mode <= MODE_I. An in-flight read is dropped with no grant.
- Write buffer (1 entry):
  - STORE_I && STORE_PERM_O loads DATA_I.
  - STORE_PERM_O = !TRG_DELAYED_O && (buffer empty || buffer draining this cycle) && !(stream && FILL_O + buf_valid >= DEPTH).
  - STORE_I while STORE_PERM_O=0: word dropped, OVERFLOW_O <= 1.
- Port arbiter: one access per cycle.
  - Only one of write/read pending: that one is served.
  - Both pending: the priority bit alternates, starting with write after reset/clear; it toggles only on conflict cycles.
- Write commit:
  - MEM_WE_O=1, addr = wr_ptr; wr_ptr <= wr_ptr+1 mod DEPTH.
  - If FILL_O < DEPTH, FILL_O +1.
  - Else (trace mode only) FILL_O is held and rd_ptr <= rd_ptr+1 (oldest discarded).
- Read FSM: R_IDLE -> R_ISSUE -> R_CAPT -> R_IDLE.
  - R_IDLE -> R_ISSUE: LOAD_REQUEST_I=1 with FILL_O>0. The request is latched and need not be held.
  - R_ISSUE, when granted the port: addr = rd_ptr; rd_ptr +1; FILL_O -1; go to R_CAPT.
  - R_CAPT: DATA_O <= MEM_RDATA_I, LOAD_GRANT_O=1 for one cycle, back to R_IDLE.
  - Latency request-to-grant: 2 cycles uncontended, 3 when losing arbitration once.
  - Request with FILL_O=0: stays in R_IDLE; the request is not remembered.
- Trigger:
  - First TRG_EVENT_I after reset/clear: EVENT_ADDR_O <= wr_ptr; trigger flag set sticky.
  - post = (TRG_DELAY_I * DEPTH) >> DELAY_BITS, sampled at the trigger.
  - Post counter decrements per write commit. TRG_DELAYED_O=1 the cycle after it reaches 0; post=0 gives TRG_DELAYED_O one cycle after the trigger.
  - Trace mode: TRG_DELAYED_O blocks stores until clear, but a buffered word still commits.
  - Stream mode: the trigger is recorded but TRG_DELAYED_O stays 0.
- Simultaneous trigger and store: the store counts toward post.
- Pointer arithmetic wraps mod DEPTH; FILL_O saturates at DEPTH.

Optional Feature:
TRACE_LOGGER_DROP_CNT_EN:
- Defined: adds output DROP_CNT_O [15:0], a saturating count of dropped stores, cleared by reset/CLEAR_I.
- Undefined: port and counter are absent; only OVERFLOW_O reports drops.

Test Plan:
- Stream, DEPTH=8, 9 back-to-back stores 1..9 -> FILL_O=8; STORE_PERM_O low before 9th; OVERFLOW_O=1; reads return 1..8.
- Trace, DEPTH=8, 12 stores 1..12 then 8 reads -> FILL_O stays 8; reads return 5..12.
- Trace, DELAY_BITS=3, TRG_DELAY_I=4, DEPTH=8, trigger at wr_ptr=3 -> EVENT_ADDR_O=3; TRG_DELAYED_O rises after 4 further commits; later stores dropped.
- Continuous STORE_I with LOAD_REQUEST_I pulse -> grant within 3 cycles; no store lost while STORE_PERM_O=1.
- Read in flight, CLEAR_I asserted in R_CAPT -> no LOAD_GRANT_O; FILL_O=0, pointers 0, mode reloaded.
- With TRACE_LOGGER_DROP_CNT_EN, 3 stores while TRG_DELAYED_O=1 -> DROP_CNT_O=3.

Source files
------------

// File: rtl/trace_logger_ring.sv
// trace_logger_ring
//   Ring-buffer trace logger that sits between the Tracer and a single-port
//   trace RAM. It has a one-entry write buffer, an internal write/read port
//   arbiter, a three-state read FSM and trigger-delay control. In trace mode
//   the ring overwrites its oldest entries. In stream mode it acts as a
//   lossless FIFO.
//
//   Optional feature macro: TRACE_LOGGER_DROP_CNT_EN adds DROP_CNT_O, a
//   16-bit saturating count of dropped stores.
//
// Ports
//   CLK_I, RST_NI        clock, async active-low reset
//   CLEAR_I, MODE_I      sync clear (latches MODE_I: 0 trace, 1 stream)
//   TRG_DELAY_I          post-trigger fraction of DEPTH
//   TRG_EVENT_I          trigger event in
//   TRG_DELAYED_O        trigger seen and post-trigger writes done
//   EVENT_ADDR_O         write pointer captured at the first trigger
//   STORE_I, DATA_I      store strobe and trace word
//   STORE_PERM_O         store is accepted this cycle
//   LOAD_REQUEST_I       read request
//   LOAD_GRANT_O         one-cycle pulse while DATA_O is valid
//   DATA_O               read word
//   FILL_O               committed entries, 0..DEPTH
//   OVERFLOW_O           sticky flag: a store was dropped
//   MEM_*                RAM port, read data one cycle after the address
module trace_logger_ring #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 64,
  parameter int DELAY_BITS = 3,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  CLK_I,
  input  logic                  RST_NI,
  input  logic                  CLEAR_I,
  input  logic                  MODE_I,
  input  logic [DELAY_BITS-1:0] TRG_DELAY_I,
  input  logic                  TRG_EVENT_I,
  output logic                  TRG_DELAYED_O,
  output logic [AW-1:0]         EVENT_ADDR_O,
  input  logic                  STORE_I,
  input  logic [WIDTH-1:0]      DATA_I,
  output logic                  STORE_PERM_O,
  input  logic                  LOAD_REQUEST_I,
  output logic                  LOAD_GRANT_O,
  output logic [WIDTH-1:0]      DATA_O,
  output logic [AW:0]           FILL_O,
  output logic                  OVERFLOW_O,
`ifdef TRACE_LOGGER_DROP_CNT_EN
  output logic [15:0]           DROP_CNT_O,
`endif
  output logic                  MEM_WE_O,
  output logic [AW-1:0]         MEM_ADDR_O,
  output logic [WIDTH-1:0]      MEM_WDATA_O,
  input  logic [WIDTH-1:0]      MEM_RDATA_I
);

  typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_CAPT} rstate_e;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  rstate_e          rstate_q, rstate_d;
  logic             mode_q, mode_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;
  logic             buf_vld_q, buf_vld_d;
  logic [WIDTH-1:0] buf_data_q, buf_data_d;
  logic             ovf_q, ovf_d;
  logic             prio_q, prio_d;       // 0: write wins next conflict
  logic [WIDTH-1:0] data_q, data_d;
  logic             trig_q, trig_d;
  logic [AW-1:0]    evt_q, evt_d;
  logic [AW-1:0]    post_q, post_d;
  logic             dly_q, dly_d;
`ifdef TRACE_LOGGER_DROP_CNT_EN
  logic [15:0]      drop_cnt_q, drop_cnt_d;
`endif

  logic          wr_pend, rd_pend, wr_gnt, rd_gnt, perm, strm_full;
  logic [AW+1:0] occ;
  logic [AW-1:0] post_new;

  // (TRG_DELAY_I * DEPTH) >> DELAY_BITS. DEPTH is a power of two, so this
  // is a plain bit placement of the delay fraction.
  if (AW > DELAY_BITS) begin : g_post_wide
    assign post_new = {TRG_DELAY_I, {(AW-DELAY_BITS){1'b0}}};
  end else begin : g_post_narrow
    assign post_new = TRG_DELAY_I[DELAY_BITS-1 -: AW];
  end

  // Clear overrides everything, so no RAM access is granted while it is high.
  assign wr_pend   = buf_vld_q;
  assign rd_pend   = (rstate_q == R_ISSUE);
  assign wr_gnt    = !CLEAR_I && wr_pend && (!rd_pend || !prio_q);
  assign rd_gnt    = !CLEAR_I && rd_pend && (!wr_pend || prio_q);

  // In stream mode the buffered word already reserves a ring slot.
  assign occ       = {1'b0, fill_q} + {{(AW+1){1'b0}}, buf_vld_q};
  assign strm_full = mode_q && (occ >= (AW+2)'(DEPTH));
  assign perm      = RST_NI && !CLEAR_I && !dly_q && (!buf_vld_q || wr_gnt) && !strm_full;

  always_comb begin
    rstate_d   = rstate_q;
    mode_d     = mode_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fill_d     = fill_q;
    buf_vld_d  = buf_vld_q;
    buf_data_d = buf_data_q;
    ovf_d      = ovf_q;
    prio_d     = prio_q;
    data_d     = data_q;
    trig_d     = trig_q;
    evt_d      = evt_q;
    post_d     = post_q;
    dly_d      = dly_q;
`ifdef TRACE_LOGGER_DROP_CNT_EN
    drop_cnt_d = drop_cnt_q;
`endif

    if (wr_gnt) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      buf_vld_d = 1'b0;
      if (fill_q < FULL) fill_d = fill_q + (AW+1)'(1);
      else if (!mode_q)  rd_ptr_d = rd_ptr_q + AW'(1);  // drop the oldest entry
      if (trig_q && (post_q != '0)) begin
        post_d = post_q - AW'(1);
        if ((post_q == AW'(1)) && !mode_q) dly_d = 1'b1;
      end
    end

    if (rd_gnt) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      fill_d   = fill_q - (AW+1)'(1);
    end

    if (wr_pend && rd_pend) prio_d = ~prio_q;

    case (rstate_q)
      R_IDLE:  if (LOAD_REQUEST_I && (fill_q != '0)) rstate_d = R_ISSUE;
      R_ISSUE: if (rd_gnt) rstate_d = R_CAPT;
      R_CAPT: begin
        data_d   = MEM_RDATA_I;
        rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase

    if (STORE_I) begin
      if (perm) begin
        buf_vld_d  = 1'b1;
        buf_data_d = DATA_I;
      end else begin
        ovf_d = 1'b1;
`ifdef TRACE_LOGGER_DROP_CNT_EN
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
`endif
      end
    end

    if (TRG_EVENT_I && !trig_q) begin
      trig_d = 1'b1;
      evt_d  = wr_ptr_q;
      post_d = post_new;
      if ((post_new == '0) && !mode_q) dly_d = 1'b1;
    end

    if (CLEAR_I) begin
      rstate_d   = R_IDLE;
      mode_d     = MODE_I;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fill_d     = '0;
      buf_vld_d  = 1'b0;
      buf_data_d = '0;
      ovf_d      = 1'b0;
      prio_d     = 1'b0;
      data_d     = '0;
      trig_d     = 1'b0;
      evt_d      = '0;
      post_d     = '0;
      dly_d      = 1'b0;
`ifdef TRACE_LOGGER_DROP_CNT_EN
      drop_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rstate_q   <= R_IDLE;
      mode_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      buf_vld_q  <= 1'b0;
      buf_data_q <= '0;
      ovf_q      <= 1'b0;
      prio_q     <= 1'b0;
      data_q     <= '0;
      trig_q     <= 1'b0;
      evt_q      <= '0;
      post_q     <= '0;
      dly_q      <= 1'b0;
`ifdef TRACE_LOGGER_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      rstate_q   <= rstate_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      buf_vld_q  <= buf_vld_d;
      buf_data_q <= buf_data_d;
      ovf_q      <= ovf_d;
      prio_q     <= prio_d;
      data_q     <= data_d;
      trig_q     <= trig_d;
      evt_q      <= evt_d;
      post_q     <= post_d;
      dly_q      <= dly_d;
`ifdef TRACE_LOGGER_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // RAM data is passed straight through in R_CAPT so that the grant pulse
  // and a valid word appear together. data_q holds the word afterwards.
  assign DATA_O        = (rstate_q == R_CAPT) ? MEM_RDATA_I : data_q;
  assign LOAD_GRANT_O  = (rstate_q == R_CAPT) && !CLEAR_I;
  assign STORE_PERM_O  = perm;
  assign TRG_DELAYED_O = dly_q;
  assign EVENT_ADDR_O  = evt_q;
  assign FILL_O        = fill_q;
  assign OVERFLOW_O    = ovf_q;
  assign MEM_WE_O      = wr_gnt;
  assign MEM_ADDR_O    = wr_gnt ? wr_ptr_q : rd_ptr_q;
  assign MEM_WDATA_O   = buf_data_q;
`ifdef TRACE_LOGGER_DROP_CNT_EN
  assign DROP_CNT_O    = drop_cnt_q;
`endif

endmodule
